// File: rtl/tty_pkg.sv
// Shared types and register map for the tty port controller.
package tty_pkg;

  typedef enum logic [2:0] {
    R_IDLE, R_SETTLE, R_CAPTURE, R_ACK, R_GAP
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_WAIT, T_SETUP, T_STROBE
  } tx_state_t;

  localparam logic [1:0] A_RXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  localparam int S_DTR     = 0;
  localparam int S_TX_BUSY = 1;
  localparam int S_TX_OVR  = 2;
  localparam int S_RX_OVR  = 3;

endpackage

// File: rtl/tty_rx_fifo.sv
// Small receive FIFO; count is one bit wider than the pointers so full never aliases empty.
module tty_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tty_port_ctrl.sv
// Memory-mapped tty port: receive/transmit handshakes, RX FIFO and CPU register decode.
module tty_port_ctrl
  import tty_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 10,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  input  logic [7:0] tty_td,
  input  logic       tty_rts,
  output logic       tty_cts,
  output logic [7:0] tty_rd,
  output logic       tty_dsr,
  input  logic       tty_dtr
);

  localparam int CNT_MAX = (SETTLE_CYCLES > STROBE_CYCLES) ? SETTLE_CYCLES : STROBE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d, tx_cnt, tx_cnt_d;
  logic rts_meta, rts_s, dtr_meta, dtr_s;
  logic rx_ie, tx_ie, rx_ovr, tx_ovr;
  logic fifo_push, fifo_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [$clog2(FIFO_DEPTH):0] rx_count;
  logic rd_en, wr_en, rx_udr, tx_wr, ctrl_wr, tx_busy;

  // Two-flop synchronisers for the asynchronous terminal handshake lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rts_meta, rts_s, dtr_meta, dtr_s} <= '0;
    end else begin
      rts_meta <= tty_rts;
      rts_s    <= rts_meta;
      dtr_meta <= tty_dtr;
      dtr_s    <= dtr_meta;
    end
  end

  assign rd_en    = cs & ~we;
  assign wr_en    = cs & we;
  assign fifo_pop = rd_en & (addr == A_RXDATA) & ~rx_empty;
  assign rx_udr   = rd_en & (addr == A_RXDATA) & rx_empty;
  assign tx_wr    = wr_en & (addr == A_TXDATA);
  assign ctrl_wr  = wr_en & (addr == A_CTRL);
  assign tx_busy  = (tx_state != T_IDLE);
  assign tty_cts  = (rx_state == R_ACK);
  assign tty_dsr  = (tx_state == T_STROBE);
  assign irq      = (rx_ie & ~rx_empty) | (tx_ie & ~tx_busy);

  tty_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(fifo_push), .din(tty_td), .pop(fifo_pop),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      tx_state <= T_IDLE;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
      rx_cnt   <= rx_cnt_d;
      tx_cnt   <= tx_cnt_d;
    end
  end

  // No new receive starts while the FIFO is full, which holds the terminal off
  always_comb begin
    rx_next   = rx_state;
    rx_cnt_d  = rx_cnt;
    fifo_push = 1'b0;
    case (rx_state)
      R_IDLE:    if (rts_s && !rx_full) begin rx_next = R_SETTLE; rx_cnt_d = '0; end
      R_SETTLE:  if (!rts_s) rx_next = R_IDLE;
                 else if (rx_cnt == SETTLE_LAST) rx_next = R_CAPTURE;
                 else rx_cnt_d = rx_cnt + CNT_W'(1);
      R_CAPTURE: begin fifo_push = 1'b1; rx_next = R_ACK; rx_cnt_d = '0; end
      R_ACK:     if (rx_cnt == STROBE_LAST) begin rx_next = R_GAP; rx_cnt_d = '0; end
                 else rx_cnt_d = rx_cnt + CNT_W'(1);
      R_GAP:     if (rx_cnt == SETTLE_LAST) rx_next = R_IDLE;
                 else rx_cnt_d = rx_cnt + CNT_W'(1);
      default:   rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    tx_next  = tx_state;
    tx_cnt_d = tx_cnt;
    case (tx_state)
      T_IDLE:   if (tx_wr) tx_next = T_WAIT;
      T_WAIT:   if (dtr_s) tx_next = T_SETUP;
      T_SETUP:  begin tx_next = T_STROBE; tx_cnt_d = '0; end
      T_STROBE: if (tx_cnt == STROBE_LAST) tx_next = T_IDLE;
                else tx_cnt_d = tx_cnt + CNT_W'(1);
      default:  tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tty_rd <= 8'h00;
      rx_ie  <= 1'b0;
      tx_ie  <= 1'b0;
      rx_ovr <= 1'b0;
      tx_ovr <= 1'b0;
    end else begin
      if (tx_wr && !tx_busy) tty_rd <= wdata;
      if (ctrl_wr) begin
        rx_ie <= wdata[0];
        tx_ie <= wdata[1];
      end
      if (ctrl_wr && wdata[7]) rx_ovr <= 1'b0;
      else if (rx_udr)         rx_ovr <= 1'b1;
      if (ctrl_wr && wdata[7])  tx_ovr <= 1'b0;
      else if (tx_wr && tx_busy) tx_ovr <= 1'b1;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (rd_en) begin
      case (addr)
        A_RXDATA: rdata = rx_empty ? 8'h00 : rx_head;
        A_STATUS: rdata = {4'(rx_count), rx_ovr, tx_ovr, tx_busy, dtr_s};
        A_CTRL:   rdata = {6'b0, tx_ie, rx_ie};
        default:  rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_tty_port_ctrl.sv
// Directed bench for tty_port_ctrl: register table plus handshake sequences.
module tb_tty_port_ctrl;
  import tty_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0, we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       irq;
  logic [7:0] tty_td = 8'h00;
  logic       tty_rts = 1'b0;
  logic       tty_cts;
  logic [7:0] tty_rd;
  logic       tty_dsr;
  logic       tty_dtr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  tty_port_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(10), .STROBE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tty_td(tty_td), .tty_rts(tty_rts),
    .tty_cts(tty_cts), .tty_rd(tty_rd), .tty_dsr(tty_dsr), .tty_dtr(tty_dtr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(negedge clk);
    cs = 1'b0; addr = 2'd0;
  endtask

  task automatic wait_for(input bit sel_dsr, input logic lvl, input int max,
                          output bit ok, output int n);
    ok = 1'b0; n = 0;
    while (!ok && n < max) begin
      @(posedge clk); #1;
      n++;
      if ((sel_dsr ? tty_dsr : tty_cts) === lvl) ok = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] prev_rd;
    bit ok, rose, seen;
    int n, hi;

    vecs[0]  = '{1'b0, A_CTRL,   8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, A_STATUS, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, A_TXDATA, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, A_CTRL,   8'h02, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, A_CTRL,   8'h00, 8'h02, 1'b1};
    vecs[5]  = '{1'b1, A_CTRL,   8'h01, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, A_RXDATA, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, A_STATUS, 8'h00, 8'h08, 1'b0};
    vecs[8]  = '{1'b1, A_CTRL,   8'h83, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, A_STATUS, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, A_STATUS, 8'hFF, 8'h00, 1'b1};
    vecs[11] = '{1'b0, A_CTRL,   8'h00, 8'h03, 1'b1};
    vecs[12] = '{1'b1, A_CTRL,   8'h00, 8'h00, 1'b0};
    vecs[13] = '{1'b1, A_RXDATA, 8'h55, 8'h00, 1'b0};
    vecs[14] = '{1'b0, A_STATUS, 8'h00, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cts", tty_cts, 1'b0);
    check("rst_dsr", tty_dsr, 1'b0);
    check("rst_rd", tty_rd, 8'h00);
    check("rst_irq", irq, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Register table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) bus_write(vecs[i].a, vecs[i].wd);
      else begin
        bus_read(vecs[i].a, d);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
      end
      #1 check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
    end

    // 1: single character receive
    @(negedge clk);
    tty_td = 8'h41; tty_rts = 1'b1;
    wait_for(1'b0, 1'b1, 40, ok, n);
    check("t1_cts_rise", ok, 1'b1);
    check("t1_latency_ge12", (n >= 12), 1'b1);
    tty_rts = 1'b0;
    repeat (20) @(posedge clk);
    bus_read(A_STATUS, d);
    check("t1_status_one", d, 8'h10);
    bus_read(A_RXDATA, d);
    check("t1_rxdata", d, 8'h41);
    bus_read(A_STATUS, d);
    check("t1_rx_cnt_zero", d[7:4], 4'd0);

    // 2: five characters, FIFO holds four, fifth is backpressured
    for (int i = 0; i < 4; i++) begin
      tty_td = 8'h41 + 8'(i); tty_rts = 1'b1;
      wait_for(1'b0, 1'b1, 60, ok, n);
      check($sformatf("t2_ack%0d", i), ok, 1'b1);
      tty_td = 8'h42 + 8'(i);
      wait_for(1'b0, 1'b0, 10, ok, n);
      check($sformatf("t2_ack%0d_fall", i), ok, 1'b1);
    end
    wait_for(1'b0, 1'b1, 60, ok, n);
    check("t2_no_ack_full", ok, 1'b0);
    bus_read(A_STATUS, d);
    check("t2_status_full", d, 8'h40);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_RXDATA, d);
      check($sformatf("t2_read%0d", i), d, 8'h41 + 8'(i));
    end
    wait_for(1'b0, 1'b1, 60, ok, n);
    check("t2_fifth_ack", ok, 1'b1);
    tty_rts = 1'b0;
    repeat (20) @(posedge clk);
    bus_read(A_RXDATA, d);
    check("t2_read_fifth", d, 8'h45);
    bus_read(A_STATUS, d);
    check("t2_status_empty", d, 8'h00);

    // 3a: transmit with terminal ready
    tty_dtr = 1'b1;
    repeat (3) @(posedge clk);
    bus_write(A_TXDATA, 8'h5A);
    check("t3_rd_loaded", tty_rd, 8'h5A);
    check("t3_dsr_low_setup", tty_dsr, 1'b0);
    prev_rd = tty_rd; rose = 1'b0; hi = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (tty_dsr) begin
        if (!rose) check("t3_rd_before_dsr", prev_rd, 8'h5A);
        rose = 1'b1; hi++;
      end
      prev_rd = tty_rd;
    end
    check("t3_dsr_rose", rose, 1'b1);
    check("t3_dsr_width", hi, 2);
    bus_read(A_STATUS, d);
    check("t3_not_busy", d, 8'h01);

    // 3b: write while busy is dropped and flagged
    tty_dtr = 1'b0;
    repeat (3) @(posedge clk);
    bus_write(A_TXDATA, 8'h5A);
    bus_write(A_TXDATA, 8'hC3);
    check("t3_rd_kept", tty_rd, 8'h5A);
    bus_read(A_STATUS, d);
    check("t3_tx_ovr", d, 8'h06);
    bus_write(A_CTRL, 8'h80);
    bus_read(A_STATUS, d);
    check("t3_ovr_cleared", d, 8'h02);
    tty_dtr = 1'b1;
    wait_for(1'b1, 1'b1, 10, ok, n);
    check("t3_pending_sent", ok, 1'b1);
    repeat (5) @(posedge clk);

    // 4: transmit held off by dtr
    tty_dtr = 1'b0;
    repeat (3) @(posedge clk);
    bus_write(A_TXDATA, 8'h33);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (tty_dsr) seen = 1'b1;
    end
    check("t4_no_dsr", seen, 1'b0);
    bus_read(A_STATUS, d);
    check("t4_busy", d, 8'h02);
    check("t4_rd", tty_rd, 8'h33);
    @(negedge clk) tty_dtr = 1'b1;
    wait_for(1'b1, 1'b1, 4, ok, n);
    check("t4_dsr_within4", ok, 1'b1);
    repeat (5) @(posedge clk);

    // 5: short rts pulse, then underrun read
    @(negedge clk) tty_rts = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) tty_rts = 1'b0;
    wait_for(1'b0, 1'b1, 30, ok, n);
    check("t5_no_ack", ok, 1'b0);
    bus_read(A_RXDATA, d);
    check("t5_empty_read", d, 8'h00);
    bus_read(A_STATUS, d);
    check("t5_rx_ovr", d, 8'h09);

    // 6: reset during R_ACK and during T_STROBE
    bus_write(A_CTRL, 8'h81);
    @(negedge clk);
    tty_td = 8'h5E; tty_rts = 1'b1;
    wait_for(1'b0, 1'b1, 60, ok, n);
    check("t6_in_ack", ok, 1'b1);
    check("t6_irq_before", irq, 1'b1);
    rst_n = 1'b0; tty_rts = 1'b0;
    #1;
    check("t6_cts_async", tty_cts, 1'b0);
    check("t6_irq_after", irq, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_read(A_STATUS, d);
    check("t6_fifo_empty", d, 8'h01);
    bus_read(A_CTRL, d);
    check("t6_ctrl_reset", d, 8'h00);
    bus_write(A_TXDATA, 8'hA5);
    wait_for(1'b1, 1'b1, 10, ok, n);
    check("t6_in_strobe", ok, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_dsr_async", tty_dsr, 1'b0);
    check("t6_rd_reset", tty_rd, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_read(A_STATUS, d);
    check("t6_tx_idle", d, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
